key_encoder: RTL and testbench

- Debounced 8-to-3 priority encoder for eight active-low push buttons.
- Produces a stable 3-bit key code with a one-cycle press strobe and a one-cycle release strobe.
- Encoding is the inverse of the lab's 3-to-8 one-hot decoder: key_in[n] maps to code n.
- Sits between board buttons and downstream display/decoder logic.

---
 rtl/key_pkg.sv | 24 ++
 rtl/key_sync.sv | 24 ++
 rtl/key_encoder.sv | 130 +++++++++++++
 tb/tb_key_encoder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the debounced push-button encoder: state encoding,
// default stability window and the 8-to-3 priority function.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_FILT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_FILT = 2'd3
  } key_state_t;

  // 20 ms at 50 MHz
  localparam logic [19:0] CNT_MAX_DEF = 20'd999_999;

  function automatic logic [2:0] prio_enc8(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for asynchronous button inputs; idles at all-ones
// so a reset never looks like a press.
module key_sync #(
  parameter int WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      meta <= '1;
      dout <= '1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/key_encoder.sv
// Debounced 8-to-3 priority encoder for active-low push buttons, with
// one-cycle press and release strobes.
//
//   state        | meaning
//   IDLE         | no key pressed
//   PRESS_FILT   | candidate code must stay stable for CNT_MAX cycles
//   HELD         | press accepted, code_out valid
//   RELEASE_FILT | all keys up, waiting CNT_MAX cycles before release
module key_encoder
  import key_pkg::*;
#(
  parameter logic [19:0] CNT_MAX = CNT_MAX_DEF
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] key_in,
  output logic [2:0] code_out,
  output logic       code_valid,
  output logic       key_held,
  output logic       key_release
);

  localparam logic [19:0] CNT_LAST = CNT_MAX - 20'd1;

  logic [7:0]  key_sync_q;
  logic [7:0]  pressed;
  logic        any;
  logic [2:0]  raw_code;

  key_state_t  state, state_nxt;
  logic [19:0] cnt, cnt_nxt;
  logic [2:0]  cand, cand_nxt;
  logic [2:0]  code_nxt;
  logic        valid_nxt, release_nxt;

  key_sync #(.WIDTH(8)) u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .din       (key_in),
    .dout      (key_sync_q)
  );

  assign pressed  = ~key_sync_q;
  assign any      = |pressed;
  assign raw_code = prio_enc8(pressed);
  assign key_held = (state == HELD) || (state == RELEASE_FILT);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      cand        <= '0;
      code_out    <= '0;
      code_valid  <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      cand        <= cand_nxt;
      code_out    <= code_nxt;
      code_valid  <= valid_nxt;
      key_release <= release_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    cand_nxt    = cand;
    code_nxt    = code_out;
    valid_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (any) begin
          state_nxt = PRESS_FILT;
          cand_nxt  = raw_code;
          cnt_nxt   = '0;
        end
      end
      PRESS_FILT: begin
        if (!any) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (raw_code != cand) begin
          cand_nxt = raw_code;
          cnt_nxt  = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
          code_nxt  = cand;
          valid_nxt = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 20'd1;
        end
      end
      HELD: begin
        if (!any) begin
          state_nxt = RELEASE_FILT;
          cnt_nxt   = '0;
        end else if (raw_code != code_out) begin
          // a higher key was added or the held one dropped: re-qualify
          state_nxt = PRESS_FILT;
          cand_nxt  = raw_code;
          cnt_nxt   = '0;
        end
      end
      RELEASE_FILT: begin
        if (any) begin
          if (raw_code == code_out) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
          end else begin
            state_nxt = PRESS_FILT;
            cand_nxt  = raw_code;
            cnt_nxt   = '0;
          end
        end else if (cnt == CNT_LAST) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt + 20'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_key_encoder.sv
// Bench for key_encoder: run-length reference model checked every cycle,
// directed latency/priority/reset scenarios and a randomized button phase.
module tb_key_encoder;

  localparam int CMAX = 10;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [7:0] key_in;
  logic [2:0] code_out;
  logic       code_valid;
  logic       key_held;
  logic       key_release;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_rel    = 0;

  key_encoder #(.CNT_MAX(20'd10)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key_in      (key_in),
    .code_out    (code_out),
    .code_valid  (code_valid),
    .key_held    (key_held),
    .key_release (key_release)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: a press is accepted once the same highest key has been
  // seen for CMAX+1 consecutive synchronized samples; a release once no key
  // has been seen for CMAX+1 samples while a press is in force.
  logic [7:0] m_k1, m_k2;
  int   m_press_run, m_rel_run, m_prev_code;
  bit   m_prev_any, m_held, m_exp_valid, m_exp_rel;
  int   m_code;

  task automatic model_reset();
    m_k1 = 8'hFF; m_k2 = 8'hFF;
    m_press_run = 0; m_rel_run = 0; m_prev_code = 0; m_prev_any = 0;
    m_held = 0; m_exp_valid = 0; m_exp_rel = 0; m_code = 0;
  endtask

  task automatic model_step();
    logic [7:0] s, pr;
    bit a;
    int c;
    s = m_k2; m_k2 = m_k1; m_k1 = key_in;
    pr = ~s;
    a  = (pr != 8'h00);
    c  = 0;
    for (int i = 7; i >= 0; i--) begin
      if (pr[i]) begin c = i; break; end
    end
    m_exp_valid = 0;
    m_exp_rel   = 0;
    if (a) begin
      m_rel_run = 0;
      m_press_run = (m_prev_any && c == m_prev_code) ? m_press_run + 1 : 1;
      if (m_held) begin
        if (c != m_code) m_held = 0;
      end else if (m_press_run == CMAX + 1) begin
        m_held = 1; m_code = c; m_exp_valid = 1;
      end
    end else begin
      m_press_run = 0;
      if (m_held) begin
        m_rel_run++;
        if (m_rel_run == CMAX + 1) begin
          m_held = 0; m_exp_rel = 1; m_rel_run = 0;
        end
      end else begin
        m_rel_run = 0;
      end
    end
    m_prev_any  = a;
    m_prev_code = c;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge sys_clk or negedge sys_rst_n);
      if (!sys_rst_n) model_reset();
      else model_step();
    end
  end

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      chk("code_out", int'(code_out), m_code);
      chk("code_valid", int'(code_valid), int'(m_exp_valid));
      chk("key_held", int'(key_held), int'(m_held));
      chk("key_release", int'(key_release), int'(m_exp_rel));
      if (code_valid) n_valid++;
      if (key_release) n_rel++;
    end
  end

  // Count rising edges until the chosen strobe is seen (0 = code_valid).
  task automatic wait_strobe(input int which, input string name, output int edges);
    edges = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge sys_clk);
      #1;
      edges++;
      if ((which == 0) ? code_valid : key_release) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s timeout: no strobe within 60 cycles", name);
    edges = -1;
  endtask

  int lat;

  initial begin
    sys_rst_n = 1'b0;
    key_in    = 8'hFF;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // idle
    n_valid = 0; n_rel = 0;
    repeat (50) @(negedge sys_clk);
    #1;
    chk("idle_valid_count", n_valid, 0);
    chk("idle_rel_count", n_rel, 0);
    chk("idle_code", int'(code_out), 0);

    // clean press and release of key 2
    @(negedge sys_clk);
    key_in = 8'b1111_1011;
    wait_strobe(0, "clean_press", lat);
    chk("clean_press_latency", lat, 13);
    chk("clean_press_code", int'(code_out), 2);
    chk("clean_press_held", int'(key_held), 1);
    @(negedge sys_clk);
    key_in = 8'hFF;
    wait_strobe(1, "clean_release", lat);
    chk("clean_release_latency", lat, 13);
    chk("clean_release_code", int'(code_out), 2);

    // bounce on key 7
    @(negedge sys_clk);
    n_valid = 0;
    for (int i = 0; i < 10; i++) begin
      key_in = (i % 2 == 0) ? 8'h7F : 8'hFF;
      repeat (3) @(negedge sys_clk);
    end
    key_in = 8'h7F;
    wait_strobe(0, "bounce_press", lat);
    chk("bounce_latency", lat, 13);
    @(negedge sys_clk);
    #1;
    chk("bounce_valid_count", n_valid, 1);
    chk("bounce_code", int'(code_out), 7);
    n_rel = 0;
    key_in = 8'hFF;
    repeat (5) @(negedge sys_clk);
    key_in = 8'h7F;
    repeat (20) @(negedge sys_clk);
    #1;
    chk("release_bounce_rel_count", n_rel, 0);
    chk("release_bounce_held", int'(key_held), 1);
    @(negedge sys_clk);
    key_in = 8'hFF;
    wait_strobe(1, "bounce_release", lat);

    // priority: key 1 held, then key 6 added
    @(negedge sys_clk);
    key_in = 8'b1111_1101;
    wait_strobe(0, "prio_first", lat);
    chk("prio_first_code", int'(code_out), 1);
    @(negedge sys_clk);
    n_rel = 0;
    key_in = 8'b1011_1101;
    wait_strobe(0, "prio_second", lat);
    chk("prio_second_latency", lat, 13);
    chk("prio_second_code", int'(code_out), 6);
    chk("prio_no_release", n_rel, 0);
    @(negedge sys_clk);
    key_in = 8'hFF;
    wait_strobe(1, "prio_release", lat);

    // simultaneous keys present from reset
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    key_in = 8'b1010_1010;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    wait_strobe(0, "simul_press", lat);
    chk("simul_code", int'(code_out), 6);
    @(negedge sys_clk);
    key_in = 8'b0010_1010;
    wait_strobe(0, "simul_add7", lat);
    chk("simul_add7_code", int'(code_out), 7);
    @(negedge sys_clk);
    key_in = 8'hFF;
    wait_strobe(1, "simul_release", lat);

    // reset while filtering key 4 (cnt reaches 5 after the 8th edge)
    @(negedge sys_clk);
    key_in = 8'b1110_1111;
    repeat (8) @(posedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("rst_code", int'(code_out), 0);
    chk("rst_valid", int'(code_valid), 0);
    chk("rst_held", int'(key_held), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    wait_strobe(0, "rst_repress", lat);
    chk("rst_repress_latency", lat, 13);
    chk("rst_repress_code", int'(code_out), 4);
    @(negedge sys_clk);
    key_in = 8'hFF;
    wait_strobe(1, "rst_release", lat);

    // randomized buttons, checked against the model every cycle
    for (int seg = 0; seg < 400; seg++) begin
      @(negedge sys_clk);
      case ($urandom_range(0, 3))
        0:       key_in = 8'hFF;
        1, 2:    key_in = ~(8'h01 << $urandom_range(0, 7));
        default: key_in = 8'($urandom);
      endcase
      repeat ($urandom_range(1, 25)) @(negedge sys_clk);
    end
    key_in = 8'hFF;
    repeat (30) @(negedge sys_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
